// File: rtl/bram_sp_fifo_ctrl.sv
// First-word-fall-through FIFO built on one external single-port RAM with async read.
// The output register is refilled from RAM (fetch) or loaded directly from the input (bypass).
module bram_sp_fifo_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic pop, push, slot_free, ram_empty, fetch, bypass, in_ready_c;

    // Port arbitration: a pending refill of the output register owns the RAM port.
    always_comb begin
        pop        = out_valid_q && out_ready;
        slot_free  = !out_valid_q || out_ready;
        ram_empty  = (ram_cnt_q == '0);
        fetch      = !ram_empty && slot_free;
        bypass     = ram_empty && slot_free;
        in_ready_c = !rst && !fetch && (ram_cnt_q != DEPTH_C);
        push       = in_valid && in_ready_c;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (fetch) begin
            out_data_d  = ram_do;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + 1'b1;
            ram_cnt_d   = ram_cnt_q - 1'b1;
        end else if (push && bypass) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        // fetch and push are mutually exclusive, so the count never moves both ways.
        if (push && !bypass) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign count     = ram_cnt_q + {{ADDR_W{1'b0}}, out_valid_q};
    assign ram_we    = push && !bypass;
    assign ram_a     = fetch ? rd_ptr_q : wr_ptr_q;
    assign ram_di    = in_data;

endmodule

// File: tb/tb_bram_sp_fifo_ctrl.sv
// Bench for bram_sp_fifo_ctrl: behavioural async-read RAM, queue scoreboard, scenario tasks.
module tb_bram_sp_fifo_ctrl;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   count;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sb [$];
    logic [ADDR_W-1:0] m_wr = '0;
    logic [ADDR_W-1:0] m_rd = '0;

    always #5 clk = ~clk;

    bram_sp_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    assign ram_do = mem[ram_a];
    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;

    // Reference model: occupancy from the scoreboard queue, port decisions derived from it.
    always @(negedge clk) begin : monitor
        int   occ, e_rc;
        logic e_ov, e_sf, e_fetch, e_byp, e_ir, e_we;
        if (rst) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
            n_cmp++;
            if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
            sb.delete();
            m_wr = '0;
            m_rd = '0;
        end else begin
            occ     = sb.size();
            e_ov    = (occ != 0);
            e_rc    = occ - int'(e_ov);
            e_sf    = !e_ov || out_ready;
            e_fetch = (e_rc != 0) && e_sf;
            e_byp   = (e_rc == 0) && e_sf;
            e_ir    = !e_fetch && (e_rc < DEPTH);
            e_we    = in_valid && e_ir && !e_byp;
            n_cmp++;
            if (count !== 6'(occ) || count > 6'(DEPTH + 1)) begin
                n_err++; $display("FAIL sb_count: got %0d want %0d", count, occ);
            end
            n_cmp++;
            if (out_valid !== e_ov) begin n_err++; $display("FAIL sb_out_valid: got %b want %b", out_valid, e_ov); end
            n_cmp++;
            if (in_ready !== e_ir) begin n_err++; $display("FAIL sb_in_ready: got %b want %b", in_ready, e_ir); end
            n_cmp++;
            if (ram_we !== e_we) begin n_err++; $display("FAIL sb_ram_we: got %b want %b", ram_we, e_we); end
            if (e_fetch) begin
                n_cmp++;
                if (ram_a !== m_rd) begin n_err++; $display("FAIL sb_rd_addr: got %0d want %0d", ram_a, m_rd); end
                m_rd = m_rd + 1'b1;
            end else if (e_we) begin
                n_cmp++;
                if (ram_a !== m_wr) begin n_err++; $display("FAIL sb_wr_addr: got %0d want %0d", ram_a, m_wr); end
                m_wr = m_wr + 1'b1;
            end
            if (e_ov) begin
                n_cmp++;
                if (out_data !== sb[0]) begin n_err++; $display("FAIL sb_out_data: got %0h want %0h", out_data, sb[0]); end
            end
            if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count == '0) break;
            step();
        end
        n_cmp++;
        if (count !== '0) begin n_err++; $display("FAIL drain_timeout: count %0d want 0", count); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            n_err++; $display("FAIL reset_state: count %0d ov %b od %0h want 0 0 0", count, out_valid, out_data);
        end
        step();
    endtask

    task automatic test_bypass();
        do_reset();
        in_valid = 1'b1; in_data = 4'hA;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || ram_we !== 1'b0) begin
            n_err++; $display("FAIL bypass_push: in_ready %b ram_we %b want 1 0", in_ready, ram_we);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || count !== 6'd1) begin
            n_err++; $display("FAIL bypass_out: ov %b od %0h count %0d want 1 a 1", out_valid, out_data, count);
        end
        step();
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 6'd9) begin n_err++; $display("FAIL b2b_count: got %0d want 9", count); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (mem[k] !== 4'(k + 2)) begin n_err++; $display("FAIL b2b_ram[%0d]: got %0h want %0h", k, mem[k], k + 2); end
        end
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 4'(i)) begin
                n_err++; $display("FAIL b2b_pop%0d: ov %b od %0h want 1 %0h", i, out_valid, out_data, i);
            end
            step();
        end
        in_valid = 1'b1; in_data = 4'hC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_no_stall: in_ready %b want 1", in_ready); end
            step();
        end
        drain();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 33; i++) begin
            in_valid = 1'b1; in_data = 4'(i % 16);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_accept%0d: in_ready %b want 1", i, in_ready); end
            step();
        end
        in_data = 4'h5;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || ram_we !== 1'b0 || count !== 6'd33) begin
            n_err++; $display("FAIL full_state: in_ready %b ram_we %b count %0d want 0 0 33", in_ready, ram_we, count);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || ram_we !== 1'b0) begin
            n_err++; $display("FAIL full_fetch: in_ready %b ram_we %b want 0 0", in_ready, ram_we);
        end
        step();
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || count !== 6'd32) begin
            n_err++; $display("FAIL full_reopen: in_ready %b count %0d want 1 32", in_ready, count);
        end
        step();
        drain();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] words [100];
        int sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0;
        for (int i = 0; i < 100; i++) words[i] = 4'($urandom_range(15));
        do_reset();
        while ((sent < 100 || rcvd < 100) && cyc < 4000) begin
            in_valid  = (sent < 100) && ($urandom_range(3) != 0);
            in_data   = words[(sent < 100) ? sent : 99];
            out_ready = (cyc < 150) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (rcvd >= 100 || out_data !== words[(rcvd < 100) ? rcvd : 99]) begin
                    n_err++; $display("FAIL rand_order%0d: got %0h", rcvd, out_data);
                end
                rcvd++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (rcvd != 100 || sent != 100) begin
            n_err++; $display("FAIL rand_done: sent %0d rcvd %0d want 100 100", sent, rcvd);
        end
    endtask

    task automatic test_collision();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 4'(10 + i);
            step();
        end
        in_data = 4'h7; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (count !== 6'd5 || in_ready !== 1'b0 || ram_we !== 1'b0 || ram_a !== 5'd0) begin
            n_err++; $display("FAIL coll_fetch: count %0d in_ready %b ram_we %b ram_a %0d want 5 0 0 0",
                              count, in_ready, ram_we, ram_a);
        end
        step();
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || count !== 6'd4) begin
            n_err++; $display("FAIL coll_resume: in_ready %b count %0d want 1 4", in_ready, count);
        end
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 4);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 6'd10) begin n_err++; $display("FAIL mid_count: got %0d want 10", count); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            n_err++; $display("FAIL mid_reset: count %0d ov %b od %0h want 0 0 0", count, out_valid, out_data);
        end
        step();
        in_valid = 1'b1; in_data = 4'h3;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 4'h3 || count !== 6'd1) begin
            n_err++; $display("FAIL mid_bypass: ov %b od %0h count %0d want 1 3 1", out_valid, out_data, count);
        end
        step();
        drain();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_bypass();
        test_back_to_back();
        test_full();
        test_random();
        test_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
